fetch_queue: RTL and testbench

Instruction fetch front end for the five-stage pipelined CPU, sitting directly upstream of the IF/ID register. Owns the program counter, drives the combinational instruction memory, and buffers fetched instructions with their PCs in a small FIFO so fetch runs ahead while the decode side is held by the hazard detection unit (`IF_ID_Write` low). It also supports a single-cycle redirect/flush for later branch support.

---
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, drives the instruction memory and
// buffers {pc, instr} pairs so fetch can run ahead while decode is stalled.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [31:0]              redirect_pc,
   input  logic                     consume,
   output logic [31:0]              im_addr,
   input  logic [31:0]              im_instr,
   output logic [31:0]              instr_out,
   output logic [31:0]              pc_out,
   output logic [31:0]              pc_plus4,
   output logic                     instr_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   fetchPc;
   logic [31:0]   pcMem    [DEPTH];
   logic [31:0]   instrMem [DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [CW-1:0] occCount;
   logic          doPush;
   logic          doPop;

   assign full        = (occCount == DEPTH_C);
   assign instr_valid = (occCount != '0);
   assign doPop       = consume && instr_valid && !flush;
   // A pop in the same cycle frees the slot, so a full queue still accepts a push.
   assign doPush      = !flush && (!full || doPop);

   assign im_addr   = fetchPc;
   assign count     = occCount;
   assign instr_out = instr_valid ? instrMem[rdPtr] : 32'h0;
   assign pc_out    = instr_valid ? pcMem[rdPtr]    : 32'h0;
   assign pc_plus4  = pc_out + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetchPc  <= RESET_PC;
         rdPtr    <= '0;
         wrPtr    <= '0;
         occCount <= '0;
      end else if (flush) begin
         fetchPc  <= redirect_pc;
         rdPtr    <= '0;
         wrPtr    <= '0;
         occCount <= '0;
      end else begin
         if (doPush) begin
            wrPtr   <= wrPtr + PW'(1);
            fetchPc <= fetchPc + 32'd4;
         end
         if (doPop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         if (doPush && !doPop) begin
            occCount <= occCount + CW'(1);
         end else if (doPop && !doPush) begin
            occCount <= occCount - CW'(1);
         end
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (doPush) begin
         pcMem[wrPtr]    <= fetchPc;
         instrMem[wrPtr] <= im_instr;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RST_PC   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        consume;
   logic [31:0] im_addr;
   logic [31:0] im_instr;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic [2:0]  count;
   logic        full;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] imWord(input logic [31:0] a);
      return {2'b00, a[31:2]} ^ 32'h1357_0000;
   endfunction

   assign im_instr = imWord(im_addr);

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .flush(flush), .redirect_pc(redirect_pc),
      .consume(consume), .im_addr(im_addr), .im_instr(im_instr),
      .instr_out(instr_out), .pc_out(pc_out), .pc_plus4(pc_plus4),
      .instr_valid(instr_valid), .count(count), .full(full)
   );

   // Reference model: a queue of {pc, instr} plus the fetch address.
   logic [63:0] mq[$];
   logic [31:0] mPc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkModel(input string tag);
      logic [31:0] ePc, eIn;
      ePc = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
      eIn = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
      chk({tag, ".im_addr"},     im_addr,            mPc);
      chk({tag, ".instr_out"},   instr_out,          eIn);
      chk({tag, ".pc_out"},      pc_out,             ePc);
      chk({tag, ".pc_plus4"},    pc_plus4,           ePc + 32'd4);
      chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, mq.size() > 0});
      chk({tag, ".count"},       {29'd0, count},     32'(mq.size()));
      chk({tag, ".full"},        {31'd0, full},      {31'd0, mq.size() == DEPTH});
   endtask

   // Apply inputs, advance the model by one cycle, clock the DUT, compare.
   task automatic step(input logic c, input logic f, input logic [31:0] r, input string tag);
      logic doPop, doPush;
      consume = c; flush = f; redirect_pc = r;
      if (f) begin
         mq.delete();
         mPc = r;
      end else begin
         doPop  = c && (mq.size() > 0);
         doPush = (mq.size() < DEPTH) || doPop;
         if (doPop) void'(mq.pop_front());
         if (doPush) begin
            mq.push_back({mPc, imWord(mPc)});
            mPc = mPc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      chkModel(tag);
   endtask

   typedef struct {
      logic        cons;
      logic        fl;
      logic [31:0] rpc;
      logic [2:0]  expCount;
      logic        expValid;
      logic        expFull;
      logic [31:0] expImAddr;
      logic [31:0] expPcOut;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0, 32'h00, 32'h00};
      vecs[1]  = '{1'b0, 1'b0, 32'h0, 3'd1, 1'b1, 1'b0, 32'h04, 32'h00};
      vecs[2]  = '{1'b0, 1'b0, 32'h0, 3'd2, 1'b1, 1'b0, 32'h08, 32'h00};
      vecs[3]  = '{1'b0, 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 32'h0C, 32'h00};
      vecs[4]  = '{1'b0, 1'b0, 32'h0, 3'd4, 1'b1, 1'b1, 32'h10, 32'h00};
      vecs[5]  = '{1'b0, 1'b0, 32'h0, 3'd4, 1'b1, 1'b1, 32'h10, 32'h00};
      vecs[6]  = '{1'b0, 1'b0, 32'h0, 3'd4, 1'b1, 1'b1, 32'h10, 32'h00};
      vecs[7]  = '{1'b1, 1'b0, 32'h0, 3'd4, 1'b1, 1'b1, 32'h14, 32'h04};
      vecs[8]  = '{1'b1, 1'b0, 32'h0, 3'd4, 1'b1, 1'b1, 32'h18, 32'h08};
      vecs[9]  = '{1'b1, 1'b0, 32'h0, 3'd4, 1'b1, 1'b1, 32'h1C, 32'h0C};
      vecs[10] = '{1'b1, 1'b0, 32'h0, 3'd4, 1'b1, 1'b1, 32'h20, 32'h10};

      rst = 1'b1; flush = 1'b0; consume = 1'b0; redirect_pc = 32'h0;
      mq.delete(); mPc = RST_PC;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.im_addr",   im_addr,   32'h100);
      chk("rst.instr_out", instr_out, 32'h0);
      chk("rst.pc_out",    pc_out,    32'h0);
      chk("rst.pc_plus4",  pc_plus4,  32'h4);
      chk("rst.valid",     {31'd0, instr_valid}, 32'd0);
      chk("rst.full",      {31'd0, full},        32'd0);
      chk("rst.count",     {29'd0, count},       32'd0);

      // Release with consume=1: one instruction per cycle from RESET_PC.
      rst = 1'b0;
      consume = 1'b1;
      #1;
      chk("start.im_addr", im_addr, 32'h100);
      for (int k = 1; k <= 6; k++) begin
         step(1'b1, 1'b0, 32'h0, "stream");
         chk("stream.pc_seq", pc_out, 32'h100 + 32'(4 * (k - 1)));
         chk("stream.count1", {29'd0, count}, 32'd1);
      end

      // Fill to full, then drain with simultaneous push.
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].cons, vecs[i].fl, vecs[i].rpc, "vec");
         chk("vec.count",   {29'd0, count},       {29'd0, vecs[i].expCount});
         chk("vec.valid",   {31'd0, instr_valid}, {31'd0, vecs[i].expValid});
         chk("vec.full",    {31'd0, full},        {31'd0, vecs[i].expFull});
         chk("vec.im_addr", im_addr,              vecs[i].expImAddr);
         chk("vec.pc_out",  pc_out,               vecs[i].expPcOut);
      end

      // Flush with count=3 and consume=1: flush wins.
      step(1'b0, 1'b1, 32'h200, "pre3");
      repeat (3) step(1'b0, 1'b0, 32'h0, "fill3");
      chk("fl.count3", {29'd0, count}, 32'd3);
      step(1'b1, 1'b1, 32'h40, "flush");
      chk("fl.count",   {29'd0, count},       32'd0);
      chk("fl.valid",   {31'd0, instr_valid}, 32'd0);
      chk("fl.instr",   instr_out,            32'h0);
      chk("fl.im_addr", im_addr,              32'h40);
      step(1'b0, 1'b0, 32'h0, "postfl");
      chk("fl.pc_out",  pc_out,               32'h40);

      // Address wrap at the top of the address space.
      step(1'b0, 1'b1, 32'hFFFF_FFFC, "wrapfl");
      step(1'b0, 1'b0, 32'h0, "wrap");
      chk("wrap.im_addr",  im_addr,  32'h0);
      chk("wrap.pc_out",   pc_out,   32'hFFFF_FFFC);
      chk("wrap.pc_plus4", pc_plus4, 32'h0);

      // Randomized traffic with occasional redirects.
      for (int i = 0; i < 400; i++) begin
         logic c, f;
         logic [31:0] r;
         c = 1'($urandom_range(0, 1));
         f = ($urandom_range(0, 15) == 0);
         r = {$urandom(), 2'b00} ^ 32'($urandom_range(0, 3) << 30);
         r[1:0] = 2'b00;
         step(c, f, r, "rand");
      end

      // Asynchronous reset between edges with count=2.
      step(1'b0, 1'b1, 32'h300, "arfl");
      repeat (2) step(1'b0, 1'b0, 32'h0, "arfill");
      chk("ar.count2", {29'd0, count}, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar.im_addr",   im_addr,   32'h100);
      chk("ar.instr_out", instr_out, 32'h0);
      chk("ar.pc_out",    pc_out,    32'h0);
      chk("ar.pc_plus4",  pc_plus4,  32'h4);
      chk("ar.valid",     {31'd0, instr_valid}, 32'd0);
      chk("ar.count",     {29'd0, count},       32'd0);
      chk("ar.full",      {31'd0, full},        32'd0);
      mq.delete(); mPc = RST_PC;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 1'b0, 32'h0, "after_ar");
      chk("ar.resume", pc_out, 32'h100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
